// File: rtl/osiris_pkg.sv
// Shared definitions for the instruction-memory loader: register offsets,
// FSM state encodings and the NOP fed to the core while it is not running.
package osiris_pkg;

    localparam logic [15:0] CTRL_OFS   = 16'h0000;
    localparam logic [15:0] STATUS_OFS = 16'h0004;
    localparam logic [15:0] CYCLES_OFS = 16'h0008;
    localparam logic [15:0] IMEM_OFS   = 16'h1000;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN_HALT    = 2'd0,
        RUN_RELEASE = 2'd1,
        RUN_RUN     = 2'd2
    } run_state_e;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_ACK    = 2'd1,
        WB_RDWAIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_slave_if.sv
// Wishbone classic slave: address decode, request strobes to the loader core
// logic, and the registered ack / read-data path with its own small FSM.
module wb_slave_if
    import osiris_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned IMEM_AW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [3:0]            i_wb_sel,
    input  logic [31:0]           i_wb_adr,
    output logic                  o_wb_ack,
    output logic [DATA_WIDTH-1:0] o_wb_dat,
    input  logic                  i_imem_owned,
    input  logic [DATA_WIDTH-1:0] i_ctrl_rd,
    input  logic [DATA_WIDTH-1:0] i_status_rd,
    input  logic [DATA_WIDTH-1:0] i_cycles_rd,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic                  o_ctrl_wr,
    output logic                  o_status_wr,
    output logic                  o_imem_wr,
    output logic                  o_imem_rd,
    output logic                  o_imem_err,
    output logic [IMEM_AW-1:0]    o_imem_idx
);

    wb_state_e             state_q;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] dat_q;

    logic                  req;
    logic                  base_hit;
    logic [15:0]           ofs;
    logic                  ctrl_hit, status_hit, cycles_hit, imem_hit;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_sel;

    // Only byte 0 carries writable bits, so the upper selects never matter.
    assign unused_sel = ^i_wb_sel[3:1];

    // Requests are only recognised in IDLE, which is what forbids back-to-back acks.
    assign req        = (state_q == WB_IDLE) && i_wb_cyc && i_wb_stb && !rst;
    assign base_hit   = (i_wb_adr[31:16] == BASE_ADDR[31:16]);
    assign ofs        = i_wb_adr[15:0];
    assign ctrl_hit   = base_hit && (ofs == CTRL_OFS);
    assign status_hit = base_hit && (ofs == STATUS_OFS);
    assign cycles_hit = base_hit && (ofs == CYCLES_OFS);
    // The window is naturally aligned to its size, so a prefix compare suffices.
    assign imem_hit   = base_hit && (ofs[15:IMEM_AW+2] == IMEM_OFS[15:IMEM_AW+2]);

    assign o_ctrl_wr   = req && i_wb_we && ctrl_hit && i_wb_sel[0];
    assign o_status_wr = req && i_wb_we && status_hit && i_wb_sel[0];
    assign o_imem_wr   = req && i_wb_we && imem_hit && i_imem_owned;
    assign o_imem_rd   = req && !i_wb_we && imem_hit && i_imem_owned;
    assign o_imem_err  = req && imem_hit && !i_imem_owned;
    assign o_imem_idx  = i_wb_adr[IMEM_AW+1:2];

    always_comb begin
        rd_mux = '0;
        if (ctrl_hit) begin
            rd_mux = i_ctrl_rd;
        end else if (status_hit) begin
            rd_mux = i_status_rd;
        end else if (cycles_hit) begin
            rd_mux = i_cycles_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    if (o_imem_rd) begin
                        state_q <= WB_RDWAIT;
                    end else if (req) begin
                        state_q <= WB_ACK;
                        ack_q   <= 1'b1;
                        dat_q   <= i_wb_we ? '0 : rd_mux;
                    end
                end
                WB_RDWAIT: begin
                    state_q <= WB_ACK;
                    ack_q   <= 1'b1;
                    dat_q   <= i_imem_rdata;
                end
                WB_ACK: begin
                    state_q <= WB_IDLE;
                    ack_q   <= 1'b0;
                    dat_q   <= '0;
                end
                default: begin
                    state_q <= WB_IDLE;
                    ack_q   <= 1'b0;
                    dat_q   <= '0;
                end
            endcase
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_dat = dat_q;

endmodule

// File: rtl/imem_loader.sv
// Host-side loader for the core: run-control FSM with reset hold, cycle counter,
// status/error bits, and the IMEM port shared between Wishbone and instruction fetch.
module imem_loader
    import osiris_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned IMEM_AW    = 8,
    parameter int unsigned RST_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [3:0]            i_wb_sel,
    input  logic [31:0]           i_wb_adr,
    input  logic [DATA_WIDTH-1:0] i_wb_dat,
    output logic                  o_wb_ack,
    output logic [DATA_WIDTH-1:0] o_wb_dat,
    input  logic [DATA_WIDTH-1:0] i_pc_IF,
    output logic [DATA_WIDTH-1:0] o_instr_ID,
    output logic                  o_core_rst,
    output logic [IMEM_AW-1:0]    o_imem_addr,
    output logic                  o_imem_we,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata
);

    run_state_e   run_q;
    logic [3:0]   hold_q;
    logic         ctrl_q;
    logic         err_q;
    logic [31:0]  cycles_q;

    logic         running;
    logic         ctrl_wr, status_wr, imem_wr, imem_rd, imem_err;
    logic [IMEM_AW-1:0] imem_idx;
    logic         unused_pc;

    assign running   = (run_q == RUN_RUN);
    assign unused_pc = ^{i_pc_IF[DATA_WIDTH-1:IMEM_AW+2], i_pc_IF[1:0]};

    wb_slave_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .IMEM_AW    (IMEM_AW)
    ) u_wb (
        .clk          (clk),
        .rst          (rst),
        .i_wb_cyc     (i_wb_cyc),
        .i_wb_stb     (i_wb_stb),
        .i_wb_we      (i_wb_we),
        .i_wb_sel     (i_wb_sel),
        .i_wb_adr     (i_wb_adr),
        .o_wb_ack     (o_wb_ack),
        .o_wb_dat     (o_wb_dat),
        .i_imem_owned (run_q == RUN_HALT),
        .i_ctrl_rd    (DATA_WIDTH'(ctrl_q)),
        .i_status_rd  (DATA_WIDTH'({err_q, running})),
        .i_cycles_rd  (DATA_WIDTH'(cycles_q)),
        .i_imem_rdata (i_imem_rdata),
        .o_ctrl_wr    (ctrl_wr),
        .o_status_wr  (status_wr),
        .o_imem_wr    (imem_wr),
        .o_imem_rd    (imem_rd),
        .o_imem_err   (imem_err),
        .o_imem_idx   (imem_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= RUN_HALT;
            hold_q   <= '0;
            ctrl_q   <= 1'b0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            if (imem_err) begin
                err_q <= 1'b1;
            end else if (status_wr && i_wb_dat[1]) begin
                err_q <= 1'b0;
            end
            if (ctrl_wr) begin
                ctrl_q <= i_wb_dat[0];
            end
            case (run_q)
                RUN_HALT: begin
                    if (ctrl_wr && i_wb_dat[0]) begin
                        run_q    <= RUN_RELEASE;
                        hold_q   <= '0;
                        cycles_q <= '0;
                    end
                end
                RUN_RELEASE: begin
                    if (ctrl_wr && !i_wb_dat[0]) begin
                        run_q <= RUN_HALT;
                    end else if (hold_q == 4'(RST_HOLD)) begin
                        run_q <= RUN_RUN;
                    end else begin
                        hold_q <= hold_q + 4'd1;
                    end
                end
                RUN_RUN: begin
                    // The cycle that samples the halt write still counts as a RUN cycle.
                    cycles_q <= cycles_q + 32'd1;
                    if (ctrl_wr && !i_wb_dat[0]) begin
                        run_q <= RUN_HALT;
                    end
                end
                default: run_q <= RUN_HALT;
            endcase
        end
    end

    assign o_core_rst   = !running;
    assign o_instr_ID   = running ? i_imem_rdata : DATA_WIDTH'(NOP_INSTR);
    assign o_imem_we    = imem_wr;
    assign o_imem_wdata = imem_wr ? i_wb_dat : '0;

    always_comb begin
        o_imem_addr = '0;
        if (running) begin
            o_imem_addr = i_pc_IF[IMEM_AW+1:2];
        end else if (imem_wr || imem_rd) begin
            o_imem_addr = imem_idx;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural 1-cycle-latency IMEM model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat;
    logic        o_wb_ack;
    logic [31:0] o_wb_dat;
    logic [31:0] pc;
    logic [31:0] o_instr_ID;
    logic        o_core_rst;
    logic [7:0]  o_imem_addr;
    logic        o_imem_we;
    logic [31:0] o_imem_wdata;
    logic [31:0] imem_rdata;
    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .i_wb_cyc     (wb_cyc),
        .i_wb_stb     (wb_stb),
        .i_wb_we      (wb_we),
        .i_wb_sel     (wb_sel),
        .i_wb_adr     (wb_adr),
        .i_wb_dat     (wb_dat),
        .o_wb_ack     (o_wb_ack),
        .o_wb_dat     (o_wb_dat),
        .i_pc_IF      (pc),
        .o_instr_ID   (o_instr_ID),
        .o_core_rst   (o_core_rst),
        .o_imem_addr  (o_imem_addr),
        .o_imem_we    (o_imem_we),
        .o_imem_wdata (o_imem_wdata),
        .i_imem_rdata (imem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_imem_we) mem[o_imem_addr] <= o_imem_wdata;
        imem_rdata <= mem[o_imem_addr];
    end

    task automatic wb_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    endtask

    task automatic wb_idle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    // Full transaction; lat counts clock edges from the sampling edge to the visible ack.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output int lat,
                           output logic we_seen, output logic [7:0] addr_seen);
        wb_drive(we, adr, dat, sel);
        #1;
        we_seen = o_imem_we;
        addr_seen = o_imem_addr;
        lat = 0;
        rd = 32'h0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (o_wb_ack) begin
                rd = o_wb_dat;
                break;
            end
        end
        if (!o_wb_ack) lat = 99;
        wb_idle();
        $display("wb %s adr=%08h wdat=%08h rdat=%08h lat=%0d", we ? "WR" : "RD", adr, dat, rd, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat; logic ws; logic [7:0] as;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (o_core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", o_core_rst); end
        checks++; if (o_wb_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", o_wb_ack); end
        checks++; if (o_wb_dat !== 32'h0) begin errors++; $display("FAIL reset_wb_dat: got %08h want 0", o_wb_dat); end
        checks++; if ({o_imem_we, o_imem_addr, o_imem_wdata} !== 41'h0) begin errors++; $display("FAIL reset_imem_port: we=%b addr=%h wdata=%h want 0", o_imem_we, o_imem_addr, o_imem_wdata); end
        checks++; if (o_instr_ID !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %08h want 00000013", o_instr_ID); end
        wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %08h want 0", rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL reset_status_lat: got %0d want 1", lat); end
        wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %08h want 0", rd); end
    endtask

    task automatic test_imem_rw();
        logic [31:0] rd; int lat; logic ws; logic [7:0] as;
        wb_xfer(1'b1, 32'h3000_1004, 32'hDEAD_BEEF, 4'hF, rd, lat, ws, as);
        checks++; if (ws !== 1'b1) begin errors++; $display("FAIL imem_wr_we: got %b want 1", ws); end
        checks++; if (as !== 8'd1) begin errors++; $display("FAIL imem_wr_addr: got %0d want 1", as); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL imem_wr_lat: got %0d want 1", lat); end
        wb_xfer(1'b1, 32'h3000_1008, 32'h1234_5678, 4'hF, rd, lat, ws, as);
        checks++; if (as !== 8'd2) begin errors++; $display("FAIL imem_wr2_addr: got %0d want 2", as); end
        wb_xfer(1'b0, 32'h3000_1004, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL imem_rd_data: got %08h want deadbeef", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL imem_rd_lat: got %0d want 2", lat); end
        checks++; if (ws !== 1'b0) begin errors++; $display("FAIL imem_rd_no_we: got %b want 0", ws); end
        wb_xfer(1'b0, 32'h3000_13FC, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (as !== 8'hFF || lat !== 2) begin errors++; $display("FAIL imem_rd_top: addr=%h lat=%0d want ff/2", as, lat); end
    endtask

    task automatic test_decode();
        logic [31:0] rd; int lat; logic ws; logic [7:0] as;
        wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL unmapped_rd: got %08h lat=%0d want 0/1", rd, lat); end
        wb_xfer(1'b1, 32'h4000_1004, 32'h5555_5555, 4'hF, rd, lat, ws, as);
        checks++; if (ws !== 1'b0 || lat !== 1) begin errors++; $display("FAIL other_base_wr: we=%b lat=%0d want 0/1", ws, lat); end
        wb_xfer(1'b1, 32'h3000_0000, 32'h1, 4'hE, rd, lat, ws, as);
        checks++; if (o_core_rst !== 1'b1) begin errors++; $display("FAIL ctrl_sel0_off: core_rst=%b want 1", o_core_rst); end
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_sel0_off_rd: got %08h want 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic a0, a1, a2;
        wb_drive(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        @(posedge clk); #1; a0 = o_wb_ack;
        @(posedge clk); #1; a1 = o_wb_ack;
        @(posedge clk); #1; a2 = o_wb_ack;
        wb_idle();
        @(posedge clk); #1;
        $display("wb RD held strobe ack pattern %b%b%b", a0, a1, a2);
        checks++; if ({a0, a1, a2} !== 3'b101) begin errors++; $display("FAIL back_to_back: got %b%b%b want 101", a0, a1, a2); end
    endtask

    task automatic test_run_start();
        int n;
        wb_drive(1'b1, 32'h3000_0000, 32'h1, 4'hF);
        @(posedge clk); #1;
        wb_idle();
        checks++; if (o_wb_ack !== 1'b1) begin errors++; $display("FAIL run_ctrl_ack: got %b want 1", o_wb_ack); end
        n = 0;
        while (o_core_rst && n < 20) begin @(posedge clk); #1; n++; end
        $display("run start: core_rst fell after %0d cycles", n);
        checks++; if (n !== 5) begin errors++; $display("FAIL run_release_delay: got %0d want 5", n); end
        pc = 32'h8; #1;
        checks++; if (o_imem_addr !== 8'd2) begin errors++; $display("FAIL fetch_addr: got %0d want 2", o_imem_addr); end
        @(posedge clk); #1;
        checks++; if (o_instr_ID !== 32'h1234_5678) begin errors++; $display("FAIL fetch_instr: got %08h want 12345678", o_instr_ID); end
        pc = 32'h404; #1;
        checks++; if (o_imem_addr !== 8'd1) begin errors++; $display("FAIL fetch_wrap_addr: got %0d want 1", o_imem_addr); end
        @(posedge clk); #1;
        checks++; if (o_instr_ID !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_wrap_instr: got %08h want deadbeef", o_instr_ID); end
        pc = 32'h0;
    endtask

    task automatic test_run_err();
        logic [31:0] rd; int lat; logic ws; logic [7:0] as;
        wb_xfer(1'b1, 32'h3000_1000, 32'hAAAA_5555, 4'hF, rd, lat, ws, as);
        checks++; if (ws !== 1'b0 || lat !== 1) begin errors++; $display("FAIL run_imem_wr: we=%b lat=%0d want 0/1", ws, lat); end
        wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL run_status_err: got %08h want 3", rd); end
        wb_xfer(1'b0, 32'h3000_1004, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL run_imem_rd: got %08h lat=%0d want 0/1", rd, lat); end
        wb_xfer(1'b1, 32'h3000_0004, 32'h2, 4'hF, rd, lat, ws, as);
        wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL run_status_clr: got %08h want 1", rd); end
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL run_ctrl_rd: got %08h want 1", rd); end
    endtask

    task automatic test_cycles();
        logic [31:0] rd; int lat; logic ws; logic [7:0] as; int n;
        wb_xfer(1'b1, 32'h3000_0000, 32'h0, 4'hF, rd, lat, ws, as);
        wb_drive(1'b1, 32'h3000_0000, 32'h1, 4'hF);
        @(posedge clk); #1;
        wb_idle();
        n = 0;
        while (o_core_rst && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 5) begin errors++; $display("FAIL cyc_release_delay: got %0d want 5", n); end
        // Two RUN cycles go by in this transaction; 98 more make 100.
        wb_xfer(1'b1, 32'h3000_1000, 32'h0, 4'hF, rd, lat, ws, as);
        repeat (98) @(posedge clk);
        #1;
        wb_drive(1'b1, 32'h3000_0000, 32'h0, 4'hF);
        @(posedge clk); #1;
        wb_idle();
        checks++; if (o_core_rst !== 1'b1) begin errors++; $display("FAIL halt_core_rst: got %b want 1", o_core_rst); end
        @(posedge clk); #1;
        wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'd101) begin errors++; $display("FAIL cycles_value: got %0d want 101", rd); end
        repeat (5) @(posedge clk);
        #1;
        wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'd101) begin errors++; $display("FAIL cycles_frozen: got %0d want 101", rd); end
        wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL halt_status: got %08h want 2", rd); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] rd; int lat; logic ws; logic [7:0] as; int acks;
        wb_drive(1'b0, 32'h3000_1004, 32'h0, 4'hF);
        @(posedge clk); #1;
        checks++; if (o_wb_ack !== 1'b0) begin errors++; $display("FAIL rdwait_no_ack: got %b want 0", o_wb_ack); end
        rst = 1'b1;
        wb_idle();
        @(posedge clk); #1;
        checks++; if (o_wb_ack !== 1'b0 || o_wb_dat !== 32'h0) begin errors++; $display("FAIL rst_mid_ack: ack=%b dat=%08h want 0/0", o_wb_ack, o_wb_dat); end
        checks++; if (o_core_rst !== 1'b1 || o_instr_ID !== 32'h13) begin errors++; $display("FAIL rst_mid_core: rst=%b instr=%08h want 1/13", o_core_rst, o_instr_ID); end
        checks++; if ({o_imem_we, o_imem_addr, o_imem_wdata} !== 41'h0) begin errors++; $display("FAIL rst_mid_imem: we=%b addr=%h wdata=%h want 0", o_imem_we, o_imem_addr, o_imem_wdata); end
        rst = 1'b0;
        acks = 0;
        repeat (3) begin @(posedge clk); #1; if (o_wb_ack) acks++; end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_late_ack: got %0d acks want 0", acks); end
        wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_status_clr: got %08h want 0", rd); end
        wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_cycles_clr: got %0d want 0", rd); end
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, lat, ws, as);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_ctrl_clr: got %08h want 0", rd); end
    endtask

    initial begin
        rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_sel = 4'h0; wb_adr = 32'h0; wb_dat = 32'h0;
        pc = 32'h0;
        test_reset();
        test_imem_rw();
        test_decode();
        test_back_to_back();
        test_run_start();
        test_run_err();
        test_cycles();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
